// File: rtl/gcd_accel.sv
//------------------------------------------------------------------------------
// gcd_accel : bus-mapped subtractive GCD engine with status, cycle count and IRQ
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gcd_accel #(
  parameter int Dw   = 32,
  parameter int Aw   = 5,
  parameter int TAGw = 3,
  parameter int SELw = 4,
  parameter int GCDw = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Dw-1:0]   s_dat_i,
  input  logic [SELw-1:0] s_sel_i,
  input  logic [Aw-1:0]   s_addr_i,
  input  logic [TAGw-1:0] s_tag_i,
  input  logic            s_stb_i,
  input  logic            s_cyc_i,
  input  logic            s_we_i,
  output logic [Dw-1:0]   s_dat_o,
  output logic            s_ack_o,
  output logic            s_err_o,
  output logic            s_rty_o,
  output logic            irq
);

  localparam logic [Aw-1:0] ADDR_STATUS = Aw'(0);
  localparam logic [Aw-1:0] ADDR_IN1    = Aw'(1);
  localparam logic [Aw-1:0] ADDR_IN2    = Aw'(2);
  localparam logic [Aw-1:0] ADDR_RESULT = Aw'(3);
  localparam logic [Aw-1:0] ADDR_CYCLES = Aw'(4);
  localparam logic [Aw-1:0] ADDR_CTRL   = Aw'(5);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [GCDw-1:0]   in1;
  logic [GCDw-1:0]   in2;
  logic [GCDw-1:0]   result;
  logic [GCDw-1:0]   cycles;
  logic [GCDw-1:0]   a;
  logic [GCDw-1:0]   b;
  logic              done;
  logic              zero_err;
  logic              irq_pending;
  logic              irq_en;

  logic              req;
  logic              busy;
  logic              wr_conflict;
  logic [GCDw-1:0]   wdata;
  logic [Dw-1:0]     rdata;
  logic              unused_inputs;

  assign req         = s_stb_i & s_cyc_i & ~s_ack_o & ~s_err_o;
  assign busy        = (state == S_RUN);
  assign wr_conflict = busy & ((s_addr_i == ADDR_IN1) | (s_addr_i == ADDR_IN2));
  assign wdata       = s_dat_i[GCDw-1:0];
  assign s_rty_o     = 1'b0;
  assign irq         = irq_pending & irq_en;
  assign unused_inputs = ^{s_sel_i, s_tag_i, s_dat_i};

  always_comb begin
    rdata = '0;
    case (s_addr_i)
      ADDR_STATUS: rdata[3:0]      = {irq_pending, zero_err, busy, done};
      ADDR_IN1:    rdata[GCDw-1:0] = in1;
      ADDR_IN2:    rdata[GCDw-1:0] = in2;
      ADDR_RESULT: rdata[GCDw-1:0] = result;
      ADDR_CYCLES: rdata[GCDw-1:0] = cycles;
      ADDR_CTRL:   rdata[0]        = irq_en;
      default:     rdata           = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      in1         <= '0;
      in2         <= '0;
      result      <= '0;
      cycles      <= '0;
      a           <= '0;
      b           <= '0;
      done        <= 1'b0;
      zero_err    <= 1'b0;
      irq_pending <= 1'b0;
      irq_en      <= 1'b0;
      s_dat_o     <= '0;
      s_ack_o     <= 1'b0;
      s_err_o     <= 1'b0;
    end else begin
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      s_dat_o <= '0;

      if (state == S_RUN) begin
        if (cycles != {GCDw{1'b1}}) begin
          cycles <= cycles + GCDw'(1);
        end
        if ((a == '0) || (b == '0) || (a == b)) begin
          result      <= ((a == '0) || (b == '0)) ? (a | b) : a;
          zero_err    <= (a == '0) && (b == '0);
          done        <= 1'b1;
          irq_pending <= 1'b1;
          state       <= S_DONE;
        end else if (a > b) begin
          a <= a - b;
        end else begin
          b <= b - a;
        end
      end

      // Bus handling follows the engine so a same-cycle STATUS clear overrides
      // the pending flag raised by a terminating RUN cycle.
      if (req) begin
        if (s_we_i && wr_conflict) begin
          s_err_o <= 1'b1;
        end else begin
          s_ack_o <= 1'b1;
          if (s_we_i) begin
            case (s_addr_i)
              ADDR_STATUS: if (s_dat_i[3]) irq_pending <= 1'b0;
              ADDR_IN1:    in1 <= wdata;
              ADDR_IN2: begin
                in2      <= wdata;
                a        <= in1;
                b        <= wdata;
                cycles   <= '0;
                done     <= 1'b0;
                zero_err <= 1'b0;
                state    <= S_RUN;
              end
              ADDR_CTRL:   irq_en <= s_dat_i[0];
              default:     ;
            endcase
          end else begin
            s_dat_o <= rdata;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/gcd_accel.md
GCD_ACCEL -- requirements
Module: gcd_accel

Interface
REQ-001 Parameter Dw, default 32, bus data width.
REQ-002 Parameter Aw, default 5, bus address width.
REQ-003 Parameter TAGw, default 3, bus tag width.
REQ-004 Parameter SELw, default 4, byte-select width.
REQ-005 Parameter GCDw, default 32, operand/result width; 2 <= GCDw <= Dw.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 s_dat_i  input  Dw  write data.
REQ-009 s_sel_i  input  SELw  byte selects; ignored, full-word access only.
REQ-010 s_addr_i  input  Aw  word register address.
REQ-011 s_tag_i  input  TAGw  bus tag; ignored.
REQ-012 s_stb_i  input  1  strobe.
REQ-013 s_cyc_i  input  1  cycle valid.
REQ-014 s_we_i  input  1  1 = write, 0 = read.
REQ-015 s_dat_o  output  Dw  registered read data, valid with s_ack_o.
REQ-016 s_ack_o  output  1  normal termination.
REQ-017 s_err_o  output  1  error termination.
REQ-018 s_rty_o  output  1  tied 0.
REQ-019 irq  output  1  level interrupt = irq_pending & irq_en.

Function
REQ-020 Request = s_stb_i & s_cyc_i & ~s_ack_o & ~s_err_o; exactly one of s_ack_o/s_err_o SHALL pulse for one cycle in the cycle after each request.
REQ-021 Register map: 0 STATUS (R: bit0 done, bit1 busy, bit2 zero_err, bit3 irq_pending; W: bit3=1 clears irq_pending); 1 IN1 (R/W); 2 IN2 (R/W, write starts engine); 3 RESULT (R); 4 CYCLES (R); 5 CTRL (R/W, bit0 irq_en).
REQ-022 Writes store s_dat_i[GCDw-1:0]; reads return zero-extended values; unused bits read 0.
REQ-023 Undefined addresses: acknowledged with s_ack_o, read 0, write ignored.
REQ-024 Write to IN1 or IN2 while busy: s_err_o instead of s_ack_o, no register change, no restart.
REQ-025 FSM states IDLE, RUN, DONE; IDLE/DONE + accepted IN2 write -> RUN; load a<=IN1, b<=new IN2 data, CYCLES<=0, done<=0, zero_err<=0.
REQ-026 RUN, per cycle: CYCLES+1 (saturating at all-ones); if a==0 or b==0 or a==b: RESULT<=a|b when either is 0, else a; zero_err<=(a==0 & b==0); done<=1; irq_pending<=1; go to DONE; else if a>b a<=a-b, else b<=b-a.
REQ-027 busy=1 exactly in RUN; done first reads 1 in the cycle after the terminating RUN cycle.
REQ-028 DONE holds RESULT/CYCLES/flags until next start; DONE behaves as IDLE for starts.
REQ-029 Same-cycle termination and STATUS bit3 clear write: clear SHALL win.
REQ-030 Reads of RESULT/CYCLES during RUN return the previous/partial value without stalling.

Reset
REQ-031 On reset, at any time including mid-RUN: state IDLE; IN1, IN2, RESULT, CYCLES, a, b, all flags, irq_en = 0; s_dat_o=0, s_ack_o=0, s_err_o=0, irq=0; an in-flight computation is discarded.

Verification
REQ-032 IN1=48, IN2=18 -> RESULT=6, CYCLES=5, done=1, zero_err=0.
REQ-033 IN1=0, IN2=7 -> RESULT=7, CYCLES=1, zero_err=0; IN1=0, IN2=0 -> RESULT=0, zero_err=1.
REQ-034 Start 1 vs 0xFFFF (GCDw=32), write IN1 while busy -> s_err_o pulse, IN1 unchanged, final RESULT=1.
REQ-035 CTRL=1, run 48/18 -> irq=1 after done; write STATUS=0x8 -> irq=0 the next cycle.
REQ-036 Assert reset during RUN -> all outputs 0, STATUS=0 after release; new start 12/8 -> RESULT=4, CYCLES=3.
REQ-037 Read address 31 -> s_ack_o pulse, s_dat_o=0; back-to-back held s_stb_i -> ack every other cycle.
